// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and helpers for the LED matrix scanner.
// Contents:
//   scan_state_t          scan FSM state (IDLE / BLANK / DRIVE)
//   DEF_* / MAXB / *_AW   default geometry and the values derived from it
//   max_level(bw)         highest PWM level for a brightness width
//   addr_w(n)             address width for n entries (minimum 1)
//   pin_level(on, ah)     logical on/off mapped to a pin level
package led_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam int DEF_ROWS     = 6;
    localparam int DEF_COLS     = 6;
    localparam int DEF_BRIGHT_W = 3;

    localparam int MAXB   = (1 << DEF_BRIGHT_W) - 1;
    localparam int ROW_AW = $clog2(DEF_ROWS);
    localparam int COL_AW = $clog2(DEF_COLS);

    function automatic int max_level(input int bw);
        return (1 << bw) - 1;
    endfunction

    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic pin_level(input logic on, input bit active_high);
        return active_high ? on : ~on;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Application-side bus of the LED matrix scanner: scan enable, pixel
// writes into the back buffer, swap request and the status pulses.
//   master: application logic (drives enable/writes/swap_req)
//   slave : the scanner (drives swap_pending/swap_done/frame_start)
interface led_matrix_scanner_if
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int BRIGHT_W = DEF_BRIGHT_W
);

    logic                       enable;
    logic                       wr_en;
    logic [addr_w(ROWS)-1:0]    wr_row;
    logic [addr_w(COLS)-1:0]    wr_col;
    logic [BRIGHT_W-1:0]        wr_data;
    logic                       swap_req;
    logic                       swap_pending;
    logic                       swap_done;
    logic                       frame_start;

    modport master (
        output enable, wr_en, wr_row, wr_col, wr_data, swap_req,
        input  swap_pending, swap_done, frame_start
    );

    modport slave (
        input  enable, wr_en, wr_row, wr_col, wr_data, swap_req,
        output swap_pending, swap_done, frame_start
    );

endinterface

// File: rtl/led_matrix_scanner_timer.sv
// Scan timing for the LED matrix: prescaler, slot counter, row index and
// the IDLE/BLANK/DRIVE sequencing.
//
//   state | meaning
//   IDLE  | scanning off, prescaler held at 0, all pins inactive
//   BLANK | dead-time at the start of a row, BLANK_SLOTS slots
//   DRIVE | current row asserted, PWM slot k = 0..MAXB-1
//
// Ports:
//   clk, rst     clock, async active-high reset
//   enable       scanning enabled; low returns to IDLE next cycle
//   phase        current FSM state
//   slot_tick    last prescaler cycle of the current slot
//   k            PWM slot index inside DRIVE
//   row          row being scanned
//   wrap         in the final drive slot of the final row (qualify with slot_tick)
//   frame_start  registered pulse on the first BLANK cycle of row 0
module led_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int BRIGHT_W    = DEF_BRIGHT_W,
    parameter int SCAN_DIV    = 1000,
    parameter int BLANK_SLOTS = 1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output scan_state_t             phase,
    output logic                    slot_tick,
    output logic [BRIGHT_W-1:0]     k,
    output logic [addr_w(ROWS)-1:0] row,
    output logic                    wrap,
    output logic                    frame_start
);

    localparam int MAX_LVL  = max_level(BRIGHT_W);
    localparam int PRE_W    = addr_w(SCAN_DIV);
    localparam int SLOT_MAX = (BLANK_SLOTS > MAX_LVL) ? BLANK_SLOTS : MAX_LVL;
    localparam int SLOT_W   = addr_w(SLOT_MAX);
    localparam int ROW_W    = addr_w(ROWS);

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_SLOTS - 1);
    localparam logic [SLOT_W-1:0] DRIVE_LAST = SLOT_W'(MAX_LVL - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);

    logic [PRE_W-1:0]  presc;
    logic [SLOT_W-1:0] slot;

    assign slot_tick = (phase != IDLE) && (presc == PRE_LAST);
    assign k         = slot[BRIGHT_W-1:0];
    assign wrap      = (phase == DRIVE) && (slot == DRIVE_LAST) && (row == ROW_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= IDLE;
            presc       <= '0;
            slot        <= '0;
            row         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (!enable) begin
                phase <= IDLE;
                presc <= '0;
                slot  <= '0;
                row   <= '0;
            end else begin
                case (phase)
                    IDLE: begin
                        phase       <= BLANK;
                        presc       <= '0;
                        slot        <= '0;
                        row         <= '0;
                        frame_start <= 1'b1;
                    end
                    BLANK: begin
                        presc <= slot_tick ? '0 : presc + 1'b1;
                        if (slot_tick) begin
                            if (slot == BLANK_LAST) begin
                                phase <= DRIVE;
                                slot  <= '0;
                            end else begin
                                slot <= slot + 1'b1;
                            end
                        end
                    end
                    DRIVE: begin
                        presc <= slot_tick ? '0 : presc + 1'b1;
                        if (slot_tick) begin
                            if (slot == DRIVE_LAST) begin
                                phase <= BLANK;
                                slot  <= '0;
                                if (row == ROW_LAST) begin
                                    row         <= '0;
                                    frame_start <= 1'b1;
                                end else begin
                                    row <= row + 1'b1;
                                end
                            end else begin
                                slot <= slot + 1'b1;
                            end
                        end
                    end
                    default: phase <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with a double-buffered brightness
// frame buffer, PWM dimming per row slot and blanking between rows.
// Ports:
//   clk, rst   clock, async active-high reset
//   bus        application bus (slave side): enable, pixel writes,
//              swap_req in; swap_pending, swap_done, frame_start out
//   row_out    row drive pins, ROW_ACTIVE_HIGH selects polarity
//   col_out    column drive pins, COL_ACTIVE_HIGH selects polarity
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS            = DEF_ROWS,
    parameter int COLS            = DEF_COLS,
    parameter int BRIGHT_W        = DEF_BRIGHT_W,
    parameter int SCAN_DIV        = 1000,
    parameter int BLANK_SLOTS     = 1,
    parameter bit ROW_ACTIVE_HIGH = 1'b1,
    parameter bit COL_ACTIVE_HIGH = 1'b0
)(
    input  logic                 clk,
    input  logic                 rst,
    led_matrix_scanner_if.slave  bus,
    output logic [ROWS-1:0]      row_out,
    output logic [COLS-1:0]      col_out
);

    localparam logic ROW_OFF = pin_level(1'b0, ROW_ACTIVE_HIGH);
    localparam logic COL_OFF = pin_level(1'b0, COL_ACTIVE_HIGH);

    scan_state_t                phase;
    logic                       slot_tick;
    logic [BRIGHT_W-1:0]        k;
    logic [addr_w(ROWS)-1:0]    row;
    logic                       last_slot;
    logic                       frame_start;

    led_scan_timer #(
        .ROWS        (ROWS),
        .BRIGHT_W    (BRIGHT_W),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_SLOTS (BLANK_SLOTS)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (bus.enable),
        .phase       (phase),
        .slot_tick   (slot_tick),
        .k           (k),
        .row         (row),
        .wrap        (last_slot),
        .frame_start (frame_start)
    );

    assign bus.frame_start = frame_start;

    // Two pixel planes; front_sel names the one being displayed, the
    // other is the back buffer that application writes land in.
    logic [BRIGHT_W-1:0] fb0 [ROWS][COLS];
    logic [BRIGHT_W-1:0] fb1 [ROWS][COLS];
    logic                front_sel;
    logic                swap_pending;
    logic                swap_done;
    logic                wr_ok;
    logic                frame_wrap;
    logic                swap_apply;
    logic [COLS-1:0]     lit;

    assign wr_ok = bus.wr_en
                 && (int'(bus.wr_row) < ROWS)
                 && (int'(bus.wr_col) < COLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    fb0[r][c] <= '0;
                    fb1[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (front_sel)
                fb0[bus.wr_row][bus.wr_col] <= bus.wr_data;
            else
                fb1[bus.wr_row][bus.wr_col] <= bus.wr_data;
        end
    end

    // Swaps only take effect between frames so a frame is never torn; when
    // not scanning there is no frame to protect, so apply right away.
    assign frame_wrap = last_slot && slot_tick;
    assign swap_apply = swap_pending && (frame_wrap || (phase == IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            if (swap_apply) begin
                front_sel    <= ~front_sel;
                swap_pending <= 1'b0;
                swap_done    <= 1'b1;
            end else if (bus.swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    assign bus.swap_pending = swap_pending;
    assign bus.swap_done    = swap_done;

    // A column is lit for the first front[row][c] slots of the row, so
    // level 0 never lights and the top level lights every drive slot.
    always_comb begin
        lit = '0;
        for (int c = 0; c < COLS; c++) begin
            lit[c] = (k < (front_sel ? fb1[row][c] : fb0[row][c]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_out <= {ROWS{ROW_OFF}};
            col_out <= {COLS{COL_OFF}};
        end else if (phase == DRIVE) begin
            for (int r = 0; r < ROWS; r++) begin
                row_out[r] <= pin_level(int'(row) == r, ROW_ACTIVE_HIGH);
            end
            for (int c = 0; c < COLS; c++) begin
                col_out[c] <= pin_level(lit[c], COL_ACTIVE_HIGH);
            end
        end else begin
            row_out <= {ROWS{ROW_OFF}};
            col_out <= {COLS{COL_OFF}};
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with ROWS=COLS=6, BRIGHT_W=3,
// SCAN_DIV=4, BLANK_SLOTS=1: row period 32 cycles, frame 192 cycles.
// Every cycle of a scanned frame is compared against a closed-form
// expectation computed from the cycle number and a model of the buffers.
module tb_led_matrix_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] row_out;
    logic [5:0] col_out;

    int vectors     = 0;
    int miscompares = 0;

    int fr [6][6];
    int bk [6][6];
    bit pend_m;
    int wq_r[$];
    int wq_c[$];
    int wq_d[$];

    led_matrix_scanner_if #(.ROWS(6), .COLS(6), .BRIGHT_W(3)) bus ();

    led_matrix_scanner #(
        .ROWS            (6),
        .COLS            (6),
        .BRIGHT_W        (3),
        .SCAN_DIV        (4),
        .BLANK_SLOTS     (1),
        .ROW_ACTIVE_HIGH (1'b1),
        .COL_ACTIVE_HIGH (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .row_out (row_out),
        .col_out (col_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // {frame_start, swap_pending, swap_done, row_out, col_out}
    function automatic logic [14:0] obs_vec();
        return {bus.frame_start, bus.swap_pending, bus.swap_done, row_out, col_out};
    endfunction

    // Pins caused by state cycle p (0 = first BLANK cycle of row 0).
    function automatic logic [11:0] exp_pins(input int p);
        int s = p % 32;
        int r = p / 32;
        int kk;
        logic [5:0] rw = 6'b000000;
        logic [5:0] cl = 6'b111111;
        if (s >= 4) begin
            kk = (s - 4) / 4;
            rw = 6'(1 << r);
            for (int j = 0; j < 6; j++) begin
                if (kk < fr[r][j]) cl[j] = 1'b0;
            end
        end
        return {rw, cl};
    endfunction

    task automatic model_write(input int r, input int c, input int d);
        if (r < 6 && c < 6) bk[r][c] = d;
    endtask

    task automatic model_swap();
        int t;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                t = fr[r][c];
                fr[r][c] = bk[r][c];
                bk[r][c] = t;
            end
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                fr[r][c] = 0;
                bk[r][c] = 0;
            end
        end
        pend_m = 1'b0;
    endtask

    task automatic queue_write(input int r, input int c, input int d);
        wq_r.push_back(r);
        wq_c.push_back(c);
        wq_d.push_back(d);
    endtask

    // Called on the negedge of a frame's first cycle; checks cycles 1..n.
    // Queued writes go out on cycles 1.., swap_req on cycle req_at.
    task automatic run_cycles(input string name, input int n, input int req_at);
        logic [14:0] exp;
        bit req_prev;
        bit done_e;
        bit swap_now;
        int r, c, d;
        req_prev = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            done_e   = 1'b0;
            swap_now = 1'b0;
            if (i == 192) begin
                done_e = pend_m;
                if (pend_m) begin
                    pend_m   = 1'b0;
                    swap_now = 1'b1;
                end else if (req_prev) begin
                    pend_m = 1'b1;
                end
            end else if (req_prev) begin
                pend_m = 1'b1;
            end
            exp = {(i == 192), pend_m, done_e, exp_pins(i - 1)};
            check($sformatf("%s.cycle%0d", name, i), 32'(obs_vec()), 32'(exp));
            if (swap_now) model_swap();
            bus.wr_en    = 1'b0;
            bus.swap_req = 1'b0;
            if (wq_r.size() > 0) begin
                r = wq_r.pop_front();
                c = wq_c.pop_front();
                d = wq_d.pop_front();
                model_write(r, c, d);
                bus.wr_en   = 1'b1;
                bus.wr_row  = 3'(r);
                bus.wr_col  = 3'(c);
                bus.wr_data = 3'(d);
            end
            if (i == req_at) bus.swap_req = 1'b1;
            req_prev = (i == req_at);
        end
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_row   = '0;
        bus.wr_col   = '0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b0;
        rst          = 1'b1;
        model_clear();

        repeat (3) @(negedge clk);
        check("reset", 32'(obs_vec()), 32'({3'b000, 6'h00, 6'h3F}));
        rst = 1'b0;
        @(negedge clk);
        check("idle_disabled", 32'(obs_vec()), 32'({3'b000, 6'h00, 6'h3F}));

        bus.enable = 1'b1;
        @(negedge clk);
        check("first_frame_start", 32'(obs_vec()), 32'({3'b100, 6'h00, 6'h3F}));

        // blank frame: row walk with no column ever lit
        run_cycles("A", 192, -1);
        // (2,3)=4 then swap mid-frame
        queue_write(2, 3, 4);
        run_cycles("B", 192, 10);
        // frame shows (2,3)=4; stage (0,0)=7, (0,1)=0
        queue_write(0, 0, 7);
        queue_write(0, 1, 0);
        run_cycles("C", 192, 5);
        // frame shows (0,0)=7; empty the back buffer and try out-of-range writes
        queue_write(2, 3, 0);
        queue_write(6, 0, 5);
        queue_write(0, 6, 5);
        queue_write(7, 7, 7);
        run_cycles("D", 192, 20);
        // all-zero front; swap_req lands exactly on the wrap cycle
        queue_write(1, 1, 2);
        run_cycles("E", 192, 191);
        // swap still pending; a second request must not cause a second swap
        run_cycles("F", 192, 50);
        // shows (0,0)=7 and (1,1)=2; stop in the middle of row 3
        run_cycles("G", 106, -1);

        bus.enable = 1'b0;
        @(negedge clk);
        check("disable_lag", 32'(obs_vec()), 32'({3'b000, 6'b001000, 6'h3F}));
        @(negedge clk);
        check("disable_idle", 32'(obs_vec()), 32'({3'b000, 6'h00, 6'h3F}));

        // write and swap while idle
        bus.wr_en   = 1'b1;
        bus.wr_row  = 3'd5;
        bus.wr_col  = 3'd5;
        bus.wr_data = 3'd3;
        model_write(5, 5, 3);
        @(negedge clk);
        bus.wr_en    = 1'b0;
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;
        check("idle_swap_pending", 32'(obs_vec()), 32'({3'b010, 6'h00, 6'h3F}));
        @(negedge clk);
        check("idle_swap_done", 32'(obs_vec()), 32'({3'b001, 6'h00, 6'h3F}));
        model_swap();
        @(negedge clk);
        check("idle_swap_quiet", 32'(obs_vec()), 32'({3'b000, 6'h00, 6'h3F}));

        bus.enable = 1'b1;
        @(negedge clk);
        check("reenable_frame_start", 32'(obs_vec()), 32'({3'b100, 6'h00, 6'h3F}));
        run_cycles("H", 192, -1);

        // reset in row 1 drive with a swap pending
        run_cycles("I", 40, 20);
        rst = 1'b1;
        #1;
        check("rst_mid_drive", 32'(obs_vec()), 32'({3'b000, 6'h00, 6'h3F}));
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_frame_start", 32'(obs_vec()), 32'({3'b100, 6'h00, 6'h3F}));
        run_cycles("J", 192, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
